sram_stream_reader: RTL and testbench

Read-side controller for the 1R1W SRAM macros (e.g. 256x36). It accepts read requests on a valid/ready address stream and drives the macro's R0 port. It captures the read data one cycle after each request and returns it in order on a valid/ready response stream, with full backpressure support. No request or response is ever dropped. Each instance sits between a pipeline stage and the R0 port of one macro; the W0 port is driven by other logic.

---
 rtl/sram_rd_pkg.sv | 20 ++
 rtl/sram_rd_resp_buf.sv | 55 +++++
 rtl/sram_stream_reader.sv | 75 +++++++
 tb/tb_sram_stream_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_rd_pkg.sv
// sram_rd_pkg
// Shared defaults and small helpers for the SRAM read-stream controller.
//   ADDR_W_DEF / DATA_W_DEF : default macro geometry (256 x 36)
//   count_width()           : bits needed to hold an occupancy of 0..depth
//   wrap_inc()              : pointer increment that wraps at depth-1, so the
//                             buffer depth does not have to be a power of two
package sram_rd_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 36;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int wrap_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sram_rd_resp_buf.sv
// sram_rd_resp_buf
// DEPTH x DATA_W circular response buffer. It has no bypass path: a word that
// is pushed becomes visible on head_data one cycle later.
// Ports:
//   clock, reset : clock and synchronous active-high reset (clears all entries)
//   push         : write push_data at the tail entry
//   push_data    : word to store
//   pop          : retire the head entry (the caller only pops when count != 0)
//   head_data    : oldest stored word
//   count        : current occupancy, 0..DEPTH
module sram_rd_resp_buf
    import sram_rd_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int DATA_W = DATA_W_DEF,
    localparam int CNT_W = count_width(DEPTH),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    assign head_data = mem[head];

    // Push and pop in the same cycle leave the occupancy unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= PTR_W'(wrap_inc(int'(tail), DEPTH));
            end
            if (pop) begin
                head <= PTR_W'(wrap_inc(int'(head), DEPTH));
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/sram_stream_reader.sv
// sram_stream_reader
// Read-side controller for a 1R1W SRAM macro. Requests arrive on a valid/ready
// address stream and are issued straight to the macro R0 port; the read word
// is captured the cycle after issue and returned in order on a valid/ready
// response stream. Request-to-response latency is 2 cycles.
// Ports:
//   clock, reset           : sole clock (also R0_clk), synchronous active-high reset
//   req_valid/req_ready    : request handshake
//   req_addr               : read address
//   resp_valid/resp_ready  : response handshake
//   resp_data              : read word, in request order
//   sram_R0_addr/_en       : to the macro read port
//   sram_R0_data           : from the macro read port, valid the cycle after _en
module sram_stream_reader
    import sram_rd_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BUF_DEPTH = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] sram_R0_addr,
    output logic              sram_R0_en,
    input  logic [DATA_W-1:0] sram_R0_data
);

    localparam int CNT_W = count_width(BUF_DEPTH);

    logic             in_flight;
    logic             issue;
    logic             drain;
    logic [CNT_W-1:0] count;

    // A request is only accepted when the word it will return already has a
    // reserved buffer entry, counting the read still in flight. This keeps
    // req_ready independent of resp_ready.
    assign req_ready    = !reset && ((int'(count) + int'(in_flight)) < BUF_DEPTH);
    assign issue        = req_valid && req_ready;
    assign sram_R0_en   = issue;
    assign sram_R0_addr = req_addr;

    assign resp_valid = (count != '0);
    assign drain      = resp_valid && resp_ready;

    // Remembers that the macro will present a word next cycle; the macro
    // output is never sampled otherwise. Reset drops any read in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_flight <= 1'b0;
        end else begin
            in_flight <= issue;
        end
    end

    sram_rd_resp_buf #(
        .DEPTH  (BUF_DEPTH),
        .DATA_W (DATA_W)
    ) u_resp_buf (
        .clock     (clock),
        .reset     (reset),
        .push      (in_flight),
        .push_data (sram_R0_data),
        .pop       (drain),
        .head_data (resp_data),
        .count     (count)
    );

endmodule

// File: tb/tb_sram_stream_reader.sv
// tb_sram_stream_reader
// Self-checking bench: a behavioural SRAM macro, a stimulus sequence of
// directed and random phases, and a scoreboard that predicts handshake and
// response behaviour from issue times and outstanding counts.
module tb_sram_stream_reader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 36;
    localparam int DEPTH  = 3;

    logic              clock;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [ADDR_W-1:0] sram_R0_addr;
    logic              sram_R0_en;
    logic [DATA_W-1:0] sram_R0_data;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    logic [DATA_W-1:0] sram_mem [256];
    exp_t              sb_q [$];
    int                cycle       = 0;
    logic              rst_seen    = 1'b0;
    int                issued      = 0;
    int                popped      = 0;
    int                rand_issues = 0;
    int                n_checks    = 0;
    int                n_fail      = 0;

    sram_stream_reader #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .sram_R0_addr (sram_R0_addr),
        .sram_R0_en   (sram_R0_en),
        .sram_R0_data (sram_R0_data)
    );

    // Free-running clock, 10 time units per cycle.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle counter plus a record of whether the DUT saw reset at the last edge.
    always @(posedge clock) begin
        cycle    <= cycle + 1;
        rst_seen <= reset;
    end

    // Behavioural macro read port: registered read, garbage when not enabled
    // so that any sampling of an idle read port shows up as bad data.
    always @(posedge clock) begin
        logic [63:0] garbage;
        garbage = {$urandom, $urandom};
        if (sram_R0_en) begin
            sram_R0_data <= sram_mem[sram_R0_addr];
        end else begin
            sram_R0_data <= garbage[DATA_W-1:0];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h",
                     name, cycle, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] a,
                                 input logic r, input logic rst);
        @(posedge clock);
        #1;
        req_valid  = v;
        req_addr   = a;
        resp_ready = r;
        reset      = rst;
    endtask

    // Issue side of the scoreboard: the controller may accept a request while
    // fewer than DEPTH requests are issued but not yet delivered. Each accepted
    // request queues the word the memory holds at that address.
    always @(negedge clock) begin
        if (reset) begin
            checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
            checkOutput("rst_sram_en", 64'(sram_R0_en), 64'(0));
            sb_q.delete();
            issued = 0;
            popped = 0;
        end else begin
            logic exp_ready;
            logic exp_en;
            exp_ready = (issued - popped) < DEPTH;
            exp_en    = req_valid && exp_ready;
            checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
            checkOutput("sram_en", 64'(sram_R0_en), 64'(exp_en));
            if (exp_en) begin
                checkOutput("sram_addr", 64'(sram_R0_addr), 64'(req_addr));
                sb_q.push_back('{data: sram_mem[req_addr], cyc: cycle});
                issued++;
                rand_issues++;
            end
        end
    end

    // Response monitor: the oldest outstanding word must be presented from
    // two cycles after its issue until the consumer takes it.
    always begin
        @(negedge clock);
        #1;
        if (reset) begin
            if (rst_seen) begin
                checkOutput("rst_resp_valid", 64'(resp_valid), 64'(0));
                checkOutput("rst_resp_data", 64'(resp_data), 64'(0));
            end
        end else begin
            logic exp_valid;
            exp_valid = (sb_q.size() > 0) && (cycle >= sb_q[0].cyc + 2);
            checkOutput("resp_valid", 64'(resp_valid), 64'(exp_valid));
            if (exp_valid) begin
                checkOutput("resp_data", 64'(resp_data), 64'(sb_q[0].data));
                if (resp_ready) begin
                    void'(sb_q.pop_front());
                    popped++;
                end
            end
        end
    end

    // Stimulus sequence: reset, single read, streaming, backpressure,
    // reset with a read in flight, then randomized traffic.
    initial begin
        int guard;
        reset      = 1'b1;
        req_valid  = 1'b1;
        req_addr   = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = '0;
        end

        $display("[TB] reset with req_valid high");
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] single read");
        sram_mem[8'h12] = 36'h9ABCD1234;
        applyStimulus(1'b1, 8'h12, 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] streaming 16 reads");
        for (int i = 0; i < 16; i++) begin
            sram_mem[i] = DATA_W'(i * 3);
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, ADDR_W'(i), 1'b1, 1'b0);
        end
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] backpressure");
        for (int i = 0; i < 8; i++) begin
            sram_mem[8'h20 + i] = {4'hA, 32'($urandom)};
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, ADDR_W'(8'h20 + i), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 8'h26, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h27, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h21, 1'b1, 1'b0);
        repeat (5) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] reset with a read in flight");
        sram_mem[8'h05] = 36'h5A5A5A5A5;
        applyStimulus(1'b1, 8'h05, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        repeat (10) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = {4'($urandom), 32'($urandom)};
        end
        rand_issues = 0;
        guard       = 0;
        while (rand_issues < 1000 && guard < 20000) begin
            applyStimulus(1'($urandom_range(0, 1)), ADDR_W'($urandom),
                          1'($urandom_range(0, 1)), 1'b0);
            guard++;
        end
        checkOutput("random_issue_budget", 64'(rand_issues >= 1000), 64'(1));
        repeat (6) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("final_outstanding", 64'(sb_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
